datamover_job_sequencer: RTL and testbench

//  Splits one datamover job (src addr, dst addr, length in words) into chunks of at most MAX_CHUNK_WORDS.

---
 rtl/datamover_package.sv | 57 +++++
 rtl/datamover_job_sequencer.sv | 162 ++++++++++++++++
 tb/tb_datamover_job_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datamover_package.sv
// datamover_package
//   Shared types for the datamover: streamer control/flag bundles, the job
//   sequencer state encoding, and the small arithmetic helpers it uses.
package datamover_package;

  // Per-side (source/sink) programming of an HCI stream.
  typedef struct packed {
    logic        req_start;
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
  } hci_stream_ctrl_t;

  typedef struct packed {
    hci_stream_ctrl_t source;
    hci_stream_ctrl_t sink;
  } ctrl_streamer_t;

  // Per-side status returned by an HCI stream.
  typedef struct packed {
    logic ready_start;
    logic done;
  } hci_stream_flags_t;

  typedef struct packed {
    hci_stream_flags_t source;
    hci_stream_flags_t sink;
    logic              tcdm_fifo_empty;
  } flags_streamer_t;

  // Job sequencer FSM.
  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_LOAD  = 3'd1,
    SEQ_START = 3'd2,
    SEQ_RUN   = 3'd3,
    SEQ_DRAIN = 3'd4,
    SEQ_DONE  = 3'd5
  } seq_state_e;

  localparam int unsigned DEFAULT_BW = 288;

  // Payload bytes per streamer word: the top 32 bits of the TCDM word are not payload.
  function automatic int unsigned word_bytes(input int unsigned bw);
    return (bw - 32) / 8;
  endfunction

  localparam int unsigned WORD_BYTES = word_bytes(DEFAULT_BW);

  // Words to program for the next chunk: the remainder, capped at max_chunk.
  function automatic logic [31:0] chunk_words(input logic [31:0] rem,
                                              input logic [31:0] max_chunk);
    return (rem < max_chunk) ? rem : max_chunk;
  endfunction

endpackage

// File: rtl/datamover_job_sequencer.sv
// datamover_job_sequencer
//   Splits one datamover job (src/dst byte address, length in words) into
//   chunks of at most MAX_CHUNK_WORDS, programs the streamer source and sink
//   for each chunk, starts both together, waits for both to finish and for
//   the TCDM FIFO to drain, then moves on. One done_o pulse per job.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   clear_i      in   synchronous clear, aborts the job (priority over all)
//   start_i      in   job start strobe, only sampled in IDLE
//   src_addr_i   in   job source byte address
//   dst_addr_i   in   job destination byte address
//   len_words_i  in   job length in words (0 legal)
//   flags_i      in   streamer status (ready_start/done per side, fifo empty)
//   ctrl_o       out  streamer programming (req_start, base, lengths, stride)
//   busy_o       out  job in progress (any state but IDLE)
//   done_o       out  one-cycle pulse at job end
//   chunk_idx_o  out  index of the chunk currently in flight
module datamover_job_sequencer
  import datamover_package::*;
#(
  parameter int unsigned BW              = 288,
  parameter int unsigned MAX_CHUNK_WORDS = 256,
  parameter int unsigned LEN_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_words_i,
  input  flags_streamer_t  flags_i,
  output ctrl_streamer_t   ctrl_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] chunk_idx_o
);

  localparam int unsigned WB = word_bytes(BW);

  seq_state_e       state_q, state_d;

  logic [31:0]      src_q, dst_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] chunk_idx_q;
  logic             src_done_q, snk_done_q;

  logic [LEN_W-1:0] chunk;
  logic [LEN_W-1:0] rem_after;
  logic [31:0]      chunk_bytes;
  logic             handshake;
  logic             drain_exit;
  logic             job_accept;

  // Chunk size derives from the remainder only, so it stays constant from
  // LOAD until the remainder is updated on DRAIN exit.
  assign chunk       = LEN_W'(chunk_words(32'(rem_q), MAX_CHUNK_WORDS));
  assign rem_after   = rem_q - chunk;
  assign chunk_bytes = 32'(chunk) * WB;

  assign job_accept  = (state_q == SEQ_IDLE) && start_i;
  assign handshake   = (state_q == SEQ_START) &&
                       flags_i.source.ready_start && flags_i.sink.ready_start;
  assign drain_exit  = (state_q == SEQ_DRAIN) && flags_i.tcdm_fifo_empty;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEQ_IDLE;
    end else if (clear_i) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE:  if (start_i) state_d = SEQ_LOAD;
      SEQ_LOAD:  state_d = (rem_q == '0) ? SEQ_DONE : SEQ_START;
      SEQ_START: if (handshake) state_d = SEQ_RUN;
      // Stickies are registered, so a done seen in the handshake cycle or in
      // RUN is acted on one cycle later.
      SEQ_RUN:   if (src_done_q && snk_done_q) state_d = SEQ_DRAIN;
      SEQ_DRAIN: if (flags_i.tcdm_fifo_empty) state_d = (rem_after == '0) ? SEQ_DONE : SEQ_LOAD;
      SEQ_DONE:  state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  // Job registers and done stickies
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      chunk_idx_q <= '0;
      src_done_q  <= 1'b0;
      snk_done_q  <= 1'b0;
    end else if (clear_i) begin
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      chunk_idx_q <= '0;
      src_done_q  <= 1'b0;
      snk_done_q  <= 1'b0;
    end else begin
      if (job_accept) begin
        src_q       <= src_addr_i;
        dst_q       <= dst_addr_i;
        rem_q       <= len_words_i;
        chunk_idx_q <= '0;
        src_done_q  <= 1'b0;
        snk_done_q  <= 1'b0;
      end

      // Done pulses count only while a chunk is being started or running;
      // anywhere else they are stale and dropped.
      if ((state_q == SEQ_START) || (state_q == SEQ_RUN)) begin
        if (flags_i.source.done) src_done_q <= 1'b1;
        if (flags_i.sink.done)   snk_done_q <= 1'b1;
      end

      if (drain_exit) begin
        rem_q       <= rem_after;
        src_q       <= src_q + chunk_bytes;
        dst_q       <= dst_q + chunk_bytes;
        chunk_idx_q <= chunk_idx_q + LEN_W'(1);
        src_done_q  <= 1'b0;
        snk_done_q  <= 1'b0;
      end
    end
  end

  // Outputs: programming is presented from LOAD through DRAIN and is zero
  // otherwise; req_start is asserted on both sides only in START.
  always_comb begin
    ctrl_o = '0;
    busy_o = (state_q != SEQ_IDLE);
    done_o = (state_q == SEQ_DONE);
    if ((state_q == SEQ_LOAD) || (state_q == SEQ_START) ||
        (state_q == SEQ_RUN)  || (state_q == SEQ_DRAIN)) begin
      ctrl_o.source.req_start = (state_q == SEQ_START);
      ctrl_o.source.base_addr = src_q;
      ctrl_o.source.tot_len   = 32'(chunk);
      ctrl_o.source.d0_len    = 32'(chunk);
      ctrl_o.source.d0_stride = WB;
      ctrl_o.sink.req_start   = (state_q == SEQ_START);
      ctrl_o.sink.base_addr   = dst_q;
      ctrl_o.sink.tot_len     = 32'(chunk);
      ctrl_o.sink.d0_len      = 32'(chunk);
      ctrl_o.sink.d0_stride   = WB;
    end
  end

  assign chunk_idx_o = chunk_idx_q;

endmodule

// File: tb/tb_datamover_job_sequencer.sv
module tb_datamover_job_sequencer;
  import datamover_package::*;

  localparam int unsigned MAXC = 256;
  localparam int unsigned WBY  = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            clear_i;
  logic            start_i;
  logic [31:0]     src_addr_i;
  logic [31:0]     dst_addr_i;
  logic [15:0]     len_words_i;
  flags_streamer_t flags_i;
  ctrl_streamer_t  ctrl_o;
  logic            busy_o;
  logic            done_o;
  logic [15:0]     chunk_idx_o;

  always #5 clk_i = ~clk_i;

  datamover_job_sequencer #(
    .BW              (288),
    .MAX_CHUNK_WORDS (256),
    .LEN_W           (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .src_addr_i  (src_addr_i),
    .dst_addr_i  (dst_addr_i),
    .len_words_i (len_words_i),
    .flags_i     (flags_i),
    .ctrl_o      (ctrl_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .chunk_idx_o (chunk_idx_o)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the list of chunks a job must produce.
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [15:0] idx;
  } chunk_t;

  chunk_t exp_q[$];

  task automatic build_model(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    int unsigned rem;
    int unsigned c;
    logic [31:0] s;
    logic [31:0] d;
    logic [15:0] i;
    chunk_t e;
    exp_q.delete();
    rem = len;
    s = src;
    d = dst;
    i = '0;
    while (rem > 0) begin
      c = (rem > MAXC) ? MAXC : rem;
      e.src = s; e.dst = d; e.len = 16'(c); e.idx = i;
      exp_q.push_back(e);
      s = s + 32'(c * WBY);
      d = d + 32'(c * WBY);
      rem = rem - c;
      i = i + 16'd1;
    end
  endtask

  // Observations of the last job, taken from the DUT.
  int unsigned obs_chunks;
  logic [15:0] obs_last_len;
  logic [31:0] obs_last_src;
  logic [31:0] obs_last_dst;
  bit          obs_req_seen;

  // Runs one job with a behavioural streamer. Delays: rd_* cycles of req
  // before ready, dd_* cycles from handshake to done, drn cycles of non-empty
  // FIFO after both dones. abort_chunk >= 0 aborts in RUN of that chunk.
  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                         input int unsigned rd_s, input int unsigned rd_n,
                         input int unsigned dd_s, input int unsigned dd_n,
                         input int unsigned drn, input bit flicker, input bit noise,
                         input int abort_chunk, input bit abort_rst);
    int unsigned budget, req_cyc, cnt_s, cnt_n, drn_cnt, c_empty, hs_n, c_hs;
    bit waiting, in_chunk, fired_s, fired_n, finished, rs, rn, rdy_s, rdy_n, hs;
    chunk_t ec;
    build_model(src, dst, len);
    budget = 100 + (exp_q.size() + 1) * (40 + rd_s + rd_n + dd_s + dd_n + drn) * 4;
    obs_chunks = 0; obs_last_len = '0; obs_last_src = '0; obs_last_dst = '0; obs_req_seen = 0;
    req_cyc = 0; cnt_s = 0; cnt_n = 0; drn_cnt = 0; c_empty = 0; hs_n = 0; c_hs = 0;
    waiting = 0; in_chunk = 0; fired_s = 0; fired_n = 0; finished = 0;
    flags_i = '0;
    flags_i.tcdm_fifo_empty = 1'b1;
    src_addr_i = src; dst_addr_i = dst; len_words_i = len; start_i = 1'b1;
    for (int unsigned c = 1; c <= budget && !finished; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (noise) begin
        start_i     = ($urandom % 3 == 0);
        src_addr_i  = $urandom;
        dst_addr_i  = $urandom;
        len_words_i = 16'($urandom);
      end
      rs = ctrl_o.source.req_start;
      rn = ctrl_o.sink.req_start;
      chk("busy_in_job", busy_o, 1);
      if (rs || rn) begin
        chk("req_pair", rn, rs);
        obs_req_seen = 1;
      end
      if (hs_n > 0 && c == c_hs + 1) chk("req_drop_after_hs", rs, 0);
      if (waiting) chk("req_held", rs, 1);

      if (abort_chunk >= 0 && hs_n == abort_chunk + 1 && c == c_hs + 1) begin
        flags_i = '0;
        flags_i.tcdm_fifo_empty = 1'b1;
        if (!abort_rst) begin
          clear_i = 1'b1;
          @(negedge clk_i);
          clear_i = 1'b0;
        end else begin
          #2 rst_i = 1'b1;
          #1;
        end
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_ctrl_zero", (ctrl_o == '0), 1);
        chk("abort_chunk_idx", chunk_idx_o, 0);
        if (abort_rst) begin
          @(negedge clk_i);
          rst_i = 1'b0;
        end
        finished = 1;
      end else if (done_o) begin
        chk("done_model_empty", exp_q.size(), 0);
        if (len == 0) chk("zero_len_latency", c, 2);
        else          chk("drain_to_done", c - c_empty, 1);
        finished = 1;
      end else begin
        if (rs && !waiting) begin
          waiting = 1;
          req_cyc = 0;
          chk("req_expected", (exp_q.size() > 0), 1);
          if (hs_n == 0) chk("start_to_req", c, 2);
          else           chk("drain_to_load", c - c_empty, 2);
        end
        flags_i.source.done = 1'b0;
        flags_i.sink.done   = 1'b0;
        hs = 0;
        if (waiting) begin
          rdy_s = (req_cyc >= rd_s) && (!flicker || ($urandom % 4 != 0));
          rdy_n = (req_cyc >= rd_n) && (!flicker || ($urandom % 4 != 0));
          hs = rs && rn && rdy_s && rdy_n;
          req_cyc++;
        end else begin
          rdy_s = flicker ? 1'($urandom) : 1'b0;
          rdy_n = flicker ? 1'($urandom) : 1'b0;
        end
        flags_i.source.ready_start = rdy_s;
        flags_i.sink.ready_start   = rdy_n;
        if (hs) begin
          if (exp_q.size() > 0) begin
            ec = exp_q.pop_front();
            chk("src_base", ctrl_o.source.base_addr, ec.src);
            chk("dst_base", ctrl_o.sink.base_addr, ec.dst);
            chk("src_tot_len", ctrl_o.source.tot_len, 32'(ec.len));
            chk("src_d0_len", ctrl_o.source.d0_len, 32'(ec.len));
            chk("snk_tot_len", ctrl_o.sink.tot_len, 32'(ec.len));
            chk("snk_d0_len", ctrl_o.sink.d0_len, 32'(ec.len));
            chk("src_stride", ctrl_o.source.d0_stride, WBY);
            chk("snk_stride", ctrl_o.sink.d0_stride, WBY);
            chk("chunk_idx", chunk_idx_o, 32'(ec.idx));
          end
          obs_chunks++;
          obs_last_len = ctrl_o.source.tot_len[15:0];
          obs_last_src = ctrl_o.source.base_addr;
          obs_last_dst = ctrl_o.sink.base_addr;
          hs_n++;
          c_hs = c;
          waiting = 0;
          in_chunk = 1;
          fired_s = 0; fired_n = 0;
          cnt_s = dd_s; cnt_n = dd_n; drn_cnt = drn;
          flags_i.tcdm_fifo_empty = 1'b0;
        end
        if (in_chunk) begin
          if (!fired_s) begin
            if (cnt_s == 0) begin flags_i.source.done = 1'b1; fired_s = 1; end
            else cnt_s--;
          end
          if (!fired_n) begin
            if (cnt_n == 0) begin flags_i.sink.done = 1'b1; fired_n = 1; end
            else cnt_n--;
          end
          if (fired_s && fired_n) begin
            if (drn_cnt == 0) begin
              flags_i.tcdm_fifo_empty = 1'b1;
              in_chunk = 0;
              c_empty = c;
            end else begin
              drn_cnt--;
            end
          end
        end
      end
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL job_timeout: got no job end, want end within %0d cycles", budget);
    end
    flags_i = '0;
    flags_i.tcdm_fifo_empty = 1'b1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (i == 0) chk("busy_after_end", busy_o, 0);
      chk("no_extra_done", done_o, 0);
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int unsigned n;
    logic [15:0] last_len;
    logic [31:0] last_src;
    logic [31:0] last_dst;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic [15:0] rl;
    int unsigned n_exp;

    vecs[0] = '{32'h0000_0100, 32'h0000_0800, 16'd4,     1,   16'd4,   32'h0000_0100, 32'h0000_0800};
    vecs[1] = '{32'h0000_0000, 32'h0000_1000, 16'd600,   3,   16'd88,  32'h0000_4000, 32'h0000_5000};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 16'd0,     0,   16'd0,   32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h0000_0040, 32'h0000_0080, 16'd256,   1,   16'd256, 32'h0000_0040, 32'h0000_0080};
    vecs[4] = '{32'h0000_0040, 32'h0000_0080, 16'd257,   2,   16'd1,   32'h0000_2040, 32'h0000_2080};
    vecs[5] = '{32'hFFFF_F000, 32'h0000_0010, 16'd300,   2,   16'd44,  32'h0000_1000, 32'h0000_2010};
    vecs[6] = '{32'h0000_0004, 32'h0000_0008, 16'd512,   2,   16'd256, 32'h0000_2004, 32'h0000_2008};
    vecs[7] = '{32'h0000_0000, 32'h0000_0100, 16'd65535, 256, 16'd255, 32'h001F_E000, 32'h001F_E100};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; len_words_i = '0;
    flags_i = '0;
    flags_i.tcdm_fifo_empty = 1'b1;
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_ctrl_zero", (ctrl_o == '0), 1);
    chk("reset_chunk_idx", chunk_idx_o, 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_busy", busy_o, 0);

    // Table-driven jobs with an ideal streamer.
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].src, vecs[i].dst, vecs[i].len, 0, 0, 1, 1, 2, 0, 0, -1, 0);
      chk("tbl_chunks", obs_chunks, vecs[i].n);
      chk("tbl_last_len", obs_last_len, 32'(vecs[i].last_len));
      chk("tbl_last_src", obs_last_src, vecs[i].last_src);
      chk("tbl_last_dst", obs_last_dst, vecs[i].last_dst);
    end

    // Zero-length job must never raise req_start.
    run_job(32'h0000_1234, 32'h0000_5678, 16'd0, 0, 0, 1, 1, 2, 0, 0, -1, 0);
    chk("zero_len_no_req", obs_req_seen, 0);

    // Sink not ready for 5 cycles while source is ready.
    run_job(32'h0000_0200, 32'h0000_0A00, 16'd8, 0, 5, 1, 1, 2, 0, 0, -1, 0);
    chk("slow_sink_chunks", obs_chunks, 1);

    // Sink done 3 cycles before source, FIFO non-empty 4 extra cycles, start noise.
    run_job(32'h0000_0000, 32'h0000_1000, 16'd600, 0, 0, 4, 1, 6, 0, 1, -1, 0);
    chk("late_drain_chunks", obs_chunks, 3);
    chk("late_drain_last_src", obs_last_src, 32'h0000_4000);

    // Done pulses in the handshake cycle.
    run_job(32'h0000_0300, 32'h0000_0400, 16'd300, 0, 0, 0, 0, 2, 0, 0, -1, 0);
    chk("hs_done_chunks", obs_chunks, 2);

    // Clear in RUN of chunk 1 of 3, then a normal job.
    run_job(32'h0000_0000, 32'h0000_1000, 16'd600, 0, 0, 3, 3, 2, 0, 0, 1, 0);
    chk("clear_chunks_before_abort", obs_chunks, 2);
    run_job(32'h0000_0000, 32'h0000_1000, 16'd600, 0, 0, 1, 1, 2, 0, 0, -1, 0);
    chk("after_clear_chunks", obs_chunks, 3);
    chk("after_clear_last_dst", obs_last_dst, 32'h0000_5000);

    // Asynchronous reset in RUN of chunk 1 of 3, then a normal job.
    run_job(32'h0000_0000, 32'h0000_1000, 16'd600, 0, 0, 3, 3, 2, 0, 0, 1, 1);
    run_job(32'h0000_0100, 32'h0000_0800, 16'd4, 0, 0, 1, 1, 2, 0, 0, -1, 0);
    chk("after_rst_chunks", obs_chunks, 1);
    chk("after_rst_last_src", obs_last_src, 32'h0000_0100);

    // Randomised jobs against the chunk model.
    for (int j = 0; j < 25; j++) begin
      case ($urandom % 4)
        0:       rl = 16'($urandom % 8);
        1:       rl = 16'(MAXC * (1 + $urandom % 4) + ($urandom % 5) - 2);
        2:       rl = 16'($urandom % 1200);
        default: rl = 16'(MAXC * (1 + $urandom % 3));
      endcase
      n_exp = (32'(rl) + MAXC - 1) / MAXC;
      run_job($urandom, $urandom, rl,
              $urandom % 4, $urandom % 4, $urandom % 6, $urandom % 6,
              2 + $urandom % 5, 1, 1'($urandom), -1, 0);
      chk("rand_chunks", obs_chunks, n_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
